// File: rtl/frogger_pkg.sv
// Shared types for the frogger display path: game mode encoding and default lane placement.
package frogger_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        DEAD = 2'd1,
        WIN  = 2'd2
    } state_e;

    // Lane 0 sits in the least-significant slot, so lane 0 is drawn on row 2.
    localparam logic [5:0][4:0] DEFAULT_LANE_ROW = {5'd12, 5'd11, 5'd9, 5'd7, 5'd5, 5'd2};

endpackage

// File: rtl/frame_composer_if.sv
// Game-logic to LED-matrix bus: per-frame inputs and the composed red/green planes.
interface frame_composer_if #(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int NLANES = 6
);
    logic                              frame_tick;
    logic                              gameover;
    logic                              win;
    logic [$clog2(ROWS)-1:0]           frog_row;
    logic [$clog2(COLS)-1:0]           frog_col;
    logic [NLANES-1:0][COLS-1:0]       lanes;
    logic [ROWS-1:0][COLS-1:0]         RedPixels;
    logic [ROWS-1:0][COLS-1:0]         GrnPixels;
    logic                              frame_done;
    logic                              collide;
    logic [1:0]                        state;

    modport master (
        output frame_tick, gameover, win, frog_row, frog_col, lanes,
        input  RedPixels, GrnPixels, frame_done, collide, state
    );

    modport slave (
        input  frame_tick, gameover, win, frog_row, frog_col, lanes,
        output RedPixels, GrnPixels, frame_done, collide, state
    );
endinterface

// File: rtl/blink_timer.sv
// Frame-rate blink generator: phase toggles every BLINK_FRAMES ticks, held at "on" (0) while restart.
module blink_timer #(
    parameter int BLINK_FRAMES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic restart,
    output logic phase
);
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            if (cnt == CW'(BLINK_FRAMES - 1)) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/frame_composer.sv
// Composes one red/green LED frame per frame_tick from lane occupancy, frog position and game mode.
module frame_composer
    import frogger_pkg::*;
#(
    parameter int                      ROWS         = 16,
    parameter int                      COLS         = 16,
    parameter int                      NLANES       = 6,
    parameter logic [NLANES-1:0][4:0]  LANE_ROW     = DEFAULT_LANE_ROW,
    parameter int                      BLINK_FRAMES = 8
) (
    input  logic             clk,
    input  logic             reset,
    frame_composer_if.slave  bus
);
    typedef logic [COLS-1:0] row_t;

    state_e                    state_q, ns;
    logic [ROWS-1:0][COLS-1:0] lane_red, frog_mask, red_d, grn_d, red_q, grn_q;
    logic                      frog_ok, collide_d, done_q, coll_q, phase, restart;

    always_comb begin
        ns = state_q;
        if (state_q == PLAY) begin
            if (bus.gameover)  ns = DEAD;
            else if (bus.win)  ns = WIN;
        end
    end

    // Keep the timer cleared through PLAY so the entry frame and the following
    // BLINK_FRAMES-1 frames are all drawn in the "on" phase.
    assign restart = (state_q == PLAY) && !(bus.frame_tick && ns != PLAY);

    blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk     (clk),
        .reset   (reset),
        .tick    (bus.frame_tick),
        .restart (restart),
        .phase   (phase)
    );

    assign frog_ok = (int'(bus.frog_row) < ROWS) && (int'(bus.frog_col) < COLS);

    always_comb begin
        lane_red  = '0;
        frog_mask = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < NLANES; k++)
                if (int'(LANE_ROW[k]) == r) lane_red[r] = lane_red[r] | bus.lanes[k];
            if (frog_ok && int'(bus.frog_row) == r)
                frog_mask[r] = row_t'(1) << bus.frog_col;
        end
    end

    assign collide_d = (ns == PLAY) && |(lane_red & frog_mask);

    always_comb begin
        red_d = lane_red;
        grn_d = '0;
        case (ns)
            PLAY: begin
                red_d = lane_red & ~frog_mask;
                grn_d = frog_mask;
            end
            DEAD: if (!phase) red_d = lane_red | frog_mask;
            WIN: if (!phase) begin
                grn_d    = frog_mask;
                grn_d[0] = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PLAY;
            red_q   <= '0;
            grn_q   <= '0;
            done_q  <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            done_q <= bus.frame_tick;
            coll_q <= bus.frame_tick && collide_d;
            if (bus.frame_tick) begin
                state_q <= ns;
                red_q   <= red_d;
                grn_q   <= grn_d;
            end
        end
    end

    assign bus.RedPixels  = red_q;
    assign bus.GrnPixels  = grn_q;
    assign bus.frame_done = done_q;
    assign bus.collide    = coll_q;
    assign bus.state      = state_q;
endmodule
